// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl: registered bidirectional pad controller.
// Owns the pad enable through a direction FSM that inserts TURN_CYCLES hi-Z
// cycles on every direction change. Output data is registered, and pad input
// runs through a SYNC_STAGES-deep synchroniser with a flush-qualified valid flag.
module bidir_pad_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TURN_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA_OUT,
   input  logic             OE_REQ,
   inout  wire logic [WIDTH-1:0] PAD_INOUT,
   output logic [WIDTH-1:0] DATA_IN,
   output logic             IN_VALID,
   output logic             OE_ACTIVE,
   output logic             BUSY
);

   localparam int unsigned FW = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);
   localparam logic [3:0]    TURN_LOAD  = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(SYNC_STAGES);

   typedef enum logic [1:0] {
      S_RX     = 2'd0,
      S_TO_OUT = 2'd1,
      S_DRIVE  = 2'd2,
      S_TO_IN  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [FW-1:0]     flush_q, flush_d;
   logic [WIDTH-1:0]  out_q;
   logic              oe_q;
   logic              busy_q;
   logic              valid_q;
   logic [WIDTH-1:0]  sync_q [SYNC_STAGES];

   // Next-state, turnaround counter and flush counter decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RX: begin
            if (OE_REQ) begin
               if (TURN_CYCLES == 0) begin
                  state_d = S_DRIVE;
               end else begin
                  state_d = S_TO_OUT;
                  cnt_d   = TURN_LOAD;
               end
            end
         end
         S_TO_OUT: begin
            // Abort wins over completion: a withdrawn request never reaches the pad.
            if (!OE_REQ) begin
               state_d = S_RX;
               cnt_d   = '0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_DRIVE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DRIVE: begin
            if (!OE_REQ) begin
               if (TURN_CYCLES == 0) begin
                  state_d = S_RX;
               end else begin
                  state_d = S_TO_IN;
                  cnt_d   = TURN_LOAD;
               end
            end
         end
         S_TO_IN: begin
            // Request is deliberately ignored until the far end has had its turnaround.
            if (cnt_q == 4'd0) begin
               state_d = S_RX;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_RX;
            cnt_d   = '0;
         end
      endcase

      // Held at full count outside RX so that RX entry always starts a fresh flush.
      if (state_q != S_RX) begin
         flush_d = FLUSH_LOAD;
      end else if (flush_q == '0) begin
         flush_d = '0;
      end else begin
         flush_d = flush_q - FW'(1);
      end
   end

   // Direction FSM with registered OE/BUSY/valid decodes and the output data register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_RX;
         cnt_q   <= '0;
         flush_q <= FLUSH_LOAD;
         out_q   <= '0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         oe_q    <= (state_d == S_DRIVE);
         busy_q  <= (state_d == S_TO_OUT) || (state_d == S_TO_IN);
         valid_q <= (state_d == S_RX) && (flush_d == '0);
         // Also load on the edge entering DRIVE so a zero-turnaround switch
         // presents the current DATA_OUT rather than a stale value.
         if ((state_q == S_TO_OUT) || (state_q == S_DRIVE) || (state_d == S_DRIVE)) begin
            out_q <= DATA_OUT;
         end
      end
   end

   // Input synchroniser; runs in every state so driven data loops back.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= PAD_INOUT;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Pad enable comes straight from a flop: no combinational OE_REQ -> pad path.
   assign PAD_INOUT = oe_q ? out_q : 'z;
   assign DATA_IN   = sync_q[SYNC_STAGES-1];
   assign IN_VALID  = valid_q;
   assign OE_ACTIVE = oe_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// tb_bidir_pad_ctrl: directed self-checking bench for bidir_pad_ctrl.
// Main instance uses TURN_CYCLES=2; a second instance uses TURN_CYCLES=0.
// When the DUT should be released, the bench drives the pad itself with a value
// that differs from any possible DUT contribution, so a stray drive is visible.
module tb_bidir_pad_ctrl;

   localparam int unsigned W = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [W-1:0]  DATA_OUT;
   logic          OE_REQ, OE_REQ0;
   wire  [W-1:0]  pad, pad0;
   logic          ext_en, ext0_en;
   logic [W-1:0]  ext_val, ext0_val;
   logic [W-1:0]  data_in, data_in0;
   logic          in_valid, in_valid0, oe_active, oe_active0, busy, busy0;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] sb_q [$];
   logic [W-1:0] pat [6] = '{8'h00, 8'hFF, 8'h81, 8'h5A, 8'hC3, 8'h81};
   logic [W-1:0] exp_v;

   always #5 CLK = ~CLK;

   assign pad  = ext_en  ? ext_val  : 'z;
   assign pad0 = ext0_en ? ext0_val : 'z;

   bidir_pad_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(2)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_OUT  (DATA_OUT),
      .OE_REQ    (OE_REQ),
      .PAD_INOUT (pad),
      .DATA_IN   (data_in),
      .IN_VALID  (in_valid),
      .OE_ACTIVE (oe_active),
      .BUSY      (busy)
   );

   bidir_pad_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(0)) u_dut0 (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_OUT  (DATA_OUT),
      .OE_REQ    (OE_REQ0),
      .PAD_INOUT (pad0),
      .DATA_IN   (data_in0),
      .IN_VALID  (in_valid0),
      .OE_ACTIVE (oe_active0),
      .BUSY      (busy0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1; OE_REQ = 1'b0; OE_REQ0 = 1'b0; DATA_OUT = '0;
      ext_en = 1'b1; ext_val = 8'h3C; ext0_en = 1'b1; ext0_val = 8'h3C;
      #12;
      // reset state
      chk("rst_oe",     32'(oe_active),  32'h0);
      chk("rst_busy",   32'(busy),       32'h0);
      chk("rst_valid",  32'(in_valid),   32'h0);
      chk("rst_din",    32'(data_in),    32'h0);
      chk("rst_pad",    32'(pad),        32'h3C);
      chk("rst_oe0",    32'(oe_active0), 32'h0);
      chk("rst_valid0", 32'(in_valid0),  32'h0);
      tick();
      RST = 1'b0;

      // T1: request drive, two turnaround cycles, then A5 on pad
      tick();
      chk("t1_e0_busy",  32'(busy),     32'h0);
      chk("t1_e0_valid", 32'(in_valid), 32'h0);
      OE_REQ = 1'b1; DATA_OUT = 8'hA5;
      tick();
      chk("t1_e1_busy", 32'(busy),      32'h1);
      chk("t1_e1_oe",   32'(oe_active), 32'h0);
      chk("t1_e1_pad",  32'(pad),       32'h3C);
      tick();
      chk("t1_e2_busy", 32'(busy),      32'h1);
      chk("t1_e2_oe",   32'(oe_active), 32'h0);
      ext_en = 1'b0;
      tick();
      chk("t1_e3_busy", 32'(busy),      32'h0);
      chk("t1_e3_oe",   32'(oe_active), 32'h1);
      chk("t1_e3_pad",  32'(pad),       32'hA5);

      // T6: loopback through output register and synchroniser
      for (int i = 0; i < 6; i++) begin
         DATA_OUT = pat[i];
         sb_q.push_back(pat[i]);
         tick();
         chk("t6_pad",   32'(pad),      32'(pat[i]));
         chk("t6_valid", 32'(in_valid), 32'h0);
         if (sb_q.size() == 3) begin
            exp_v = sb_q.pop_front();
            chk("t6_din", 32'(data_in), 32'(exp_v));
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_v = sb_q.pop_front();
         chk("t6_din_drain", 32'(data_in), 32'(exp_v));
      end

      // T2: release, turnaround back to RX, flush, external data seen
      OE_REQ = 1'b0;
      tick();
      chk("t2_oe",   32'(oe_active), 32'h0);
      chk("t2_busy", 32'(busy),      32'h1);
      ext_en = 1'b1; ext_val = 8'h3C;
      #1;
      chk("t2_pad_rel", 32'(pad), 32'h3C);
      tick();
      chk("t2_busy2", 32'(busy), 32'h1);
      chk("t2_pad2",  32'(pad),  32'h3C);
      tick();
      chk("t2_rx_busy",  32'(busy),     32'h0);
      chk("t2_rx_valid", 32'(in_valid), 32'h0);
      tick();
      chk("t2_flush_valid", 32'(in_valid), 32'h0);
      tick();
      chk("t2_valid", 32'(in_valid), 32'h1);
      chk("t2_din",   32'(data_in),  32'h3C);

      // T3: abort from TO_OUT, pad never driven
      OE_REQ = 1'b1; DATA_OUT = 8'hC3;
      tick();
      chk("t3_busy", 32'(busy),      32'h1);
      chk("t3_oe",   32'(oe_active), 32'h0);
      chk("t3_pad",  32'(pad),       32'h3C);
      OE_REQ = 1'b0;
      tick();
      chk("t3_abort_busy",  32'(busy),      32'h0);
      chk("t3_abort_oe",    32'(oe_active), 32'h0);
      chk("t3_abort_valid", 32'(in_valid),  32'h0);
      chk("t3_abort_pad",   32'(pad),       32'h3C);
      tick();
      chk("t3_flush_valid", 32'(in_valid),  32'h0);
      chk("t3_oe2",         32'(oe_active), 32'h0);
      chk("t3_pad2",        32'(pad),       32'h3C);
      tick();
      chk("t3_valid", 32'(in_valid), 32'h1);

      // Re-request during TO_IN is ignored until RX
      OE_REQ = 1'b1; DATA_OUT = 8'hA5;
      tick();
      tick();
      ext_en = 1'b0;
      tick();
      chk("ti_drive_oe",  32'(oe_active), 32'h1);
      chk("ti_drive_pad", 32'(pad),       32'hA5);
      OE_REQ = 1'b0;
      tick();
      chk("ti_busy1", 32'(busy), 32'h1);
      OE_REQ = 1'b1; ext_en = 1'b1;
      tick();
      chk("ti_busy2", 32'(busy),      32'h1);
      chk("ti_oe2",   32'(oe_active), 32'h0);
      tick();
      chk("ti_rx_busy", 32'(busy),      32'h0);
      chk("ti_rx_oe",   32'(oe_active), 32'h0);
      tick();
      chk("ti_reenter_busy", 32'(busy), 32'h1);

      // T5: async reset in the middle of DRIVE
      ext_en = 1'b0;
      tick();
      tick();
      chk("t5_drive_oe", 32'(oe_active), 32'h1);
      tick();
      tick();
      chk("t5_loop_din", 32'(data_in), 32'hA5);
      #2;
      RST = 1'b1; OE_REQ = 1'b0; ext_en = 1'b1;
      #1;
      chk("t5_oe",    32'(oe_active), 32'h0);
      chk("t5_din",   32'(data_in),   32'h0);
      chk("t5_busy",  32'(busy),      32'h0);
      chk("t5_valid", 32'(in_valid),  32'h0);
      chk("t5_pad",   32'(pad),       32'h3C);
      tick();
      RST = 1'b0;
      tick();
      chk("t5_rel1_valid", 32'(in_valid), 32'h0);
      tick();
      chk("t5_rel2_valid", 32'(in_valid),  32'h1);
      chk("t5_rel2_din",   32'(data_in),   32'h3C);
      chk("t5_rel2_din0",  32'(data_in0),  32'h3C);
      chk("t5_rel2_vld0",  32'(in_valid0), 32'h1);

      // T4: zero-turnaround instance, single-cycle request pulse
      OE_REQ0 = 1'b1; DATA_OUT = 8'hC3; ext0_en = 1'b0;
      tick();
      chk("t4_oe",   32'(oe_active0), 32'h1);
      chk("t4_busy", 32'(busy0),      32'h0);
      chk("t4_pad",  32'(pad0),       32'hC3);
      OE_REQ0 = 1'b0;
      tick();
      chk("t4_rel_oe",   32'(oe_active0), 32'h0);
      chk("t4_rel_busy", 32'(busy0),      32'h0);
      ext0_en = 1'b1;
      #1;
      chk("t4_rel_pad", 32'(pad0), 32'h3C);
      tick();
      chk("t4_after_oe",   32'(oe_active0), 32'h0);
      chk("t4_after_busy", 32'(busy0),      32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
